switch_config_loader: RTL and testbench
=======================================

// Module: switch_config_loader
// PURPOSE
//  Byte-stream configuration loader feeding Wilton switch boxes.
//  - Accepts framed config packets over a valid/ready byte interface.
//  - Checks each frame and holds it in a shadow buffer.
//  - On a good frame, atomically updates the 4x8-bit configuration_word of one addressed switch box.
//  - Partially received frames are never visible downstream.
// PARAMETERS
//  NUM_SWITCHES  4     number of switch boxes driven (addresses 0..NUM_SWITCHES-1)
//  SYNC_BYTE     8'hA5 frame start marker
// PORTS
//  clk                clk    input   1        single clock, rising edge
//  reset              reset  input   1        asynchronous, active-high
//  in_valid           input  1                byte present on in_data
//  in_data            input  8                frame byte
//  in_ready           output 1                loader accepts byte this cycle
//  configuration_word output [NUM_SWITCHES][4][8]  per-switch config, to WiltonSwitch
//  frame_done         output 1                1-cycle pulse: frame committed
//  frame_err          output 1                1-cycle pulse: frame rejected
//  err_count          output 8                rejected-frame count, saturates at 255
//  busy               output 1                high in any state other than HUNT
// BEHAVIOUR
//  Frame format: SYNC, ADDR, P0, P1, P2, P3, CHK.
//   - CHK = ADDR ^ P0 ^ P1 ^ P2 ^ P3.
//   - Pn lands in configuration_word[ADDR][n].
//  A byte transfers only when in_valid && in_ready; no other condition transfers a byte.
//  FSM states: HUNT, ADDR, PAYLOAD, CHECK, COMMIT.
//   - HUNT: discard bytes until SYNC_BYTE -> ADDR. Non-sync bytes are not errors.
//   - ADDR: latch address, seed running XOR with it -> PAYLOAD.
//     An out-of-range address still proceeds; it is flagged bad.
//   - PAYLOAD: 2-bit index 0..3; write shadow[idx], XOR into running sum.
//     Index 3 accepted -> CHECK.
//   - CHECK: compare byte with running XOR.
//     Match and address in range -> COMMIT; otherwise frame_err pulse -> HUNT.
//   - COMMIT: in_ready=0 for exactly this cycle.
//     Copy shadow into configuration_word[addr], frame_done pulse -> HUNT.
//  in_ready = 1 in all states except COMMIT.
//  Latency: configuration_word updates on the 2nd rising edge after the CHK byte handshake.
//   - Edge 1 enters COMMIT; edge 2 performs the copy.
//   - frame_done is high during the cycle after that copy edge.
//  Only the addressed switch changes; all other entries hold.
//  A SYNC_BYTE value inside ADDR/PAYLOAD/CHK is treated as data. There is no resync mid-frame.
//  err_count increments on each frame_err, saturating at 8'hFF.
//  Back-to-back frames: a SYNC presented in the cycle after COMMIT is accepted.
//  Reset (async, any state including mid-frame):
//   - FSM -> HUNT; shadow, running XOR and index cleared.
//   - configuration_word all 0; err_count 0.
//   - frame_done=0, frame_err=0, busy=0, in_ready=1 (from HUNT).
//  Internal widths:
//   - address register is $clog2(NUM_SWITCHES) bits plus a range-flag bit;
//   - the full 8-bit ADDR is compared against NUM_SWITCHES.
// STRUCTURE
//  Shared package cfg_pkg:
//   - typedef enum logic [2:0] {HUNT, ADDR, PAYLOAD, CHECK, COMMIT} cfg_state_t;
//   - localparam WORDS_PER_SWITCH = 4;
//   - typedef logic [7:0] cfg_byte_t;
//   - default SYNC_BYTE value.
//  Single module; no sub-module. FSM, shadow buffer and commit array all live in this file.
//  configuration_word is driven directly from the flops (registered, no combinational path from in_data).
// TESTING
//  1. Reset mid-PAYLOAD (after P1), then deassert.
//     -> busy=0, in_ready=1, all configuration_word=0.
//     -> next full frame commits normally.
//  2. Frame A5,02,11,22,33,44,CHK=02^11^22^33^44=0x46.
//     -> configuration_word[2] = {11,22,33,44} two edges after CHK handshake.
//     -> frame_done pulses once; other switches unchanged.
//  3. Same frame with CHK=0x47.
//     -> frame_err pulse, err_count=1, configuration_word[2] unchanged.
//  4. Frame with ADDR=0x04 (NUM_SWITCHES=4) and correct CHK.
//     -> frame_err, no array change, FSM back in HUNT.
//  5. Garbage 00,FF,13 then a valid frame, with in_valid toggled randomly during it.
//     -> garbage silently dropped, frame commits, err_count unchanged.
//  6. Two frames back-to-back, the second SYNC in the cycle after COMMIT.
//     -> both commit; in_ready low exactly one cycle per frame.
//     -> 256 bad frames leave err_count=255.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and constants for the switch-box configuration loader.
package cfg_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    ADDR    = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    COMMIT  = 3'd4
  } cfg_state_t;

  localparam int WORDS_PER_SWITCH = 4;

  typedef logic [7:0] cfg_byte_t;

  localparam cfg_byte_t DEFAULT_SYNC_BYTE = 8'hA5;

  // Running frame check: byte-wise XOR accumulation.
  function automatic cfg_byte_t chk_acc(input cfg_byte_t acc, input cfg_byte_t b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/switch_config_loader.sv
// Framed byte-stream loader: validates SYNC/ADDR/P0..P3/CHK frames in a shadow
// buffer and atomically commits good ones into one switch box's configuration word.
module switch_config_loader
  import cfg_pkg::*;
#(
  parameter int        NUM_SWITCHES = 4,
  parameter cfg_byte_t SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              in_valid,
  input  logic [7:0]                                        in_data,
  output logic                                              in_ready,
  output logic [NUM_SWITCHES-1:0][WORDS_PER_SWITCH-1:0][7:0] configuration_word,
  output logic                                              frame_done,
  output logic                                              frame_err,
  output logic [7:0]                                        err_count,
  output logic                                              busy
);

  localparam int AW = (NUM_SWITCHES > 1) ? $clog2(NUM_SWITCHES) : 1;

  cfg_state_t                             state;
  cfg_state_t                             next_state;
  logic [AW-1:0]                          addr;
  logic                                   addr_bad;
  logic [WORDS_PER_SWITCH-1:0][7:0]       shadow;
  cfg_byte_t                              run_xor;
  logic [1:0]                             idx;
  logic                                   accept;
  logic                                   commit;
  logic                                   reject;
  logic                                   chk_ok;

  // Both flags decode straight from the state flop, so they never glitch on in_data.
  assign in_ready = (state != COMMIT);
  assign busy     = (state != HUNT);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    commit     = 1'b0;
    reject     = 1'b0;
    chk_ok     = (in_data == run_xor) && !addr_bad;
    case (state)
      HUNT: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          next_state = ADDR;
        end else begin
          next_state = HUNT;
        end
      end
      ADDR: begin
        if (accept) begin
          next_state = PAYLOAD;
        end else begin
          next_state = ADDR;
        end
      end
      PAYLOAD: begin
        if (accept && (idx == 2'd3)) begin
          next_state = CHECK;
        end else begin
          next_state = PAYLOAD;
        end
      end
      CHECK: begin
        if (accept && chk_ok) begin
          next_state = COMMIT;
        end else if (accept) begin
          next_state = HUNT;
          reject     = 1'b1;
        end else begin
          next_state = CHECK;
        end
      end
      COMMIT: begin
        next_state = HUNT;
        commit     = 1'b1;
      end
      default: begin
        next_state = HUNT;
      end
    endcase
  end

  // Out-of-range addresses are still consumed so the frame boundary is kept; addr_bad vetoes the commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr               <= '0;
      addr_bad           <= 1'b0;
      shadow             <= '0;
      run_xor            <= 8'h00;
      idx                <= 2'd0;
      configuration_word <= '0;
      frame_done         <= 1'b0;
      frame_err          <= 1'b0;
      err_count          <= 8'h00;
    end else begin
      frame_done <= commit;
      frame_err  <= reject;
      if (reject && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      case (state)
        ADDR: begin
          if (accept) begin
            addr     <= in_data[AW-1:0];
            addr_bad <= (32'(in_data) >= NUM_SWITCHES);
            run_xor  <= in_data;
            idx      <= 2'd0;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            shadow[idx] <= in_data;
            run_xor     <= chk_acc(run_xor, in_data);
            idx         <= idx + 2'd1;
          end
        end
        COMMIT: begin
          configuration_word[addr] <= shadow;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_config_loader.sv
// Randomized scoreboard bench for switch_config_loader with a frame-level reference model.
module tb_switch_config_loader;

  typedef struct {
    bit           is_done;
    logic [127:0] cw;
    logic [7:0]   err;
    int           cyc;
  } exp_t;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic [3:0][3:0][7:0]  cw;
  logic                  frame_done;
  logic                  frame_err;
  logic [7:0]            err_count;
  logic                  busy;

  int                    total = 0;
  int                    bad = 0;
  int                    ncyc = 0;
  int                    lowcnt = 0;
  int                    ndone = 0;
  logic [127:0]          cur_cw = '0;
  logic                  prev_ready = 1'b1;
  logic [3:0][3:0][7:0]  m_cw;
  logic [7:0]            m_err;
  exp_t                  q[$];
  exp_t                  me;

  switch_config_loader dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .configuration_word (cw),
    .frame_done         (frame_done),
    .frame_err          (frame_err),
    .err_count          (err_count),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Drives one byte, optionally inserting idle cycles; d is the cycle the handshake was driven in.
  task automatic send_byte(input logic [7:0] b, input int gap, output int d);
    int tries;
    bit sent;
    tries = 0;
    sent  = 1'b0;
    d     = -100;
    while (!sent) begin
      @(negedge clk); #1;
      if (tries > 60) begin
        total++;
        bad++;
        $display("FAIL send_timeout: byte %0h not accepted, in_ready=%0b required 1", b, in_ready);
        in_valid = 1'b0;
        sent     = 1'b1;
      end else if (gap > 0 && $urandom_range(0, 99) < gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (in_ready) begin
          d    = ncyc;
          sent = 1'b1;
        end
      end
      tries++;
    end
  endtask

  task automatic idle();
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Reference model: a frame commits iff its check byte is right and the address exists.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3,
                            input logic [7:0] flip, input int gap);
    logic [7:0] c;
    int         d;
    exp_t       e;
    c = a ^ p0 ^ p1 ^ p2 ^ p3 ^ flip;
    send_byte(8'hA5, gap, d);
    send_byte(a, gap, d);
    send_byte(p0, gap, d);
    send_byte(p1, gap, d);
    send_byte(p2, gap, d);
    send_byte(p3, gap, d);
    send_byte(c, gap, d);
    if (flip == 8'h00 && a < 8'd4) begin
      m_cw[a[1:0]] = {p3, p2, p1, p0};
      e.is_done    = 1'b1;
      e.cyc        = d + 2;
    end else begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      e.is_done = 1'b0;
      e.cyc     = d + 1;
    end
    e.cw  = m_cw;
    e.err = m_err;
    q.push_back(e);
  endtask

  task automatic rand_frame(input logic [7:0] a, input logic [7:0] flip, input int gap);
    send_frame(a, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), flip, gap);
  endtask

  // Monitor: pops an expectation whenever the DUT reports a frame outcome.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (reset) begin
      cur_cw     = '0;
      prev_ready = 1'b1;
    end else begin
      if (!in_ready) lowcnt++;
      if (frame_done || frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {frame_done, frame_err}, 2'b00);
        end else begin
          me = q.pop_front();
          chk("event_kind", {frame_done, frame_err}, me.is_done ? 2'b10 : 2'b01);
          chk("event_cycle", ncyc, me.cyc);
          chk("err_count", err_count, me.err);
          chk("busy_after_frame", busy, 1'b0);
          if (me.is_done) begin
            ndone++;
            chk("cw_commit", cw, me.cw);
            chk("ready_low_in_commit", prev_ready, 1'b0);
            chk("ready_back", in_ready, 1'b1);
            cur_cw = me.cw;
          end else begin
            chk("cw_on_err", cw, cur_cw);
          end
        end
      end else begin
        chk("cw_hold", cw, cur_cw);
      end
      prev_ready = in_ready;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    m_cw     = '0;
    m_err    = 8'h00;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", in_ready, 1'b1);
    chk("reset_cw", cw, 128'd0);
    chk("reset_err_count", err_count, 8'h00);
    chk("reset_pulses", {frame_done, frame_err}, 2'b00);

    // Reset in the middle of a payload after a committed frame
    rand_frame(8'd1, 8'h00, 0);
    send_byte(8'hA5, 0, d);
    send_byte(8'h03, 0, d);
    send_byte(8'h5A, 0, d);
    send_byte(8'hC3, 0, d);
    idle();
    #1 reset = 1'b1;
    m_cw  = '0;
    m_err = 8'h00;
    #1;
    chk("midframe_rst_busy", busy, 1'b0);
    chk("midframe_rst_ready", in_ready, 1'b1);
    chk("midframe_rst_cw", cw, 128'd0);
    chk("midframe_rst_err", err_count, 8'h00);
    @(negedge clk); #1 reset = 1'b0;
    rand_frame(8'd3, 8'h00, 0);

    // Known frame, then the same frame with a bad check byte, then an out-of-range address
    send_frame(8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 0);
    send_frame(8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 0);
    send_frame(8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 0);

    // Garbage before a frame, with in_valid gaps during it
    send_byte(8'h00, 0, d);
    send_byte(8'hFF, 0, d);
    send_byte(8'h13, 0, d);
    rand_frame(8'd0, 8'h00, 40);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        send_byte(8'($urandom_range(0, 160)), 0, d);
      end
      rand_frame(8'($urandom_range(0, 5)),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 $urandom_range(0, 50));
    end

    // Back-to-back good frames, then enough bad frames to saturate the counter
    rand_frame(8'd1, 8'h00, 0);
    rand_frame(8'd2, 8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      rand_frame(8'($urandom_range(0, 3)), 8'h80, 0);
    end

    idle();
    repeat (6) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("err_saturated", err_count, 8'hFF);
    chk("ready_low_cycles", lowcnt, ndone);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
